// File: rtl/cheat_pkg.sv
// Shared definitions for the cheat loader: host opcodes, controller states,
// code bus field offsets and the payload byte placement helper.
package cheat_pkg;

  // Host opcodes, taken as the first byte of a command in IDLE
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CLEAR = 8'hC0;
  localparam logic [7:0] OP_LOAD  = 8'hC1;
  localparam logic [7:0] OP_EN    = 8'hC2;
  localparam logic [7:0] OP_DIS   = 8'hC3;

  // Code bus layout: {strobe, flags, addr, compare, replace}
  localparam int STROBE_BIT    = 128;
  localparam int FLAGS_LSB     = 96;
  localparam int ADDR_LSB      = 64;
  localparam int CMP_LSB       = 32;
  localparam int REP_LSB       = 0;
  localparam int PAYLOAD_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    SETUP   = 3'd2,
    STROBE  = 3'd3,
    RELEASE = 3'd4,
    CLR     = 3'd5
  } state_t;

  // Bit position of payload byte idx: fields arrive flags, addr, compare,
  // replace, each LSB first, so byte k of a field lands at field[8k+7:8k].
  function automatic logic [6:0] byte_offset(input logic [3:0] idx);
    logic [6:0] base;
    case (idx[3:2])
      2'd0:    base = 7'(FLAGS_LSB);
      2'd1:    base = 7'(ADDR_LSB);
      2'd2:    base = 7'(CMP_LSB);
      default: base = 7'(REP_LSB);
    endcase
    return base + {2'b00, idx[1:0], 3'b000};
  endfunction

endpackage

// File: rtl/cheat_byte_packer.sv
// 128-bit payload accumulator. Each pushed byte is placed at its field
// position (see byte_offset) and the byte index advances.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_clear     - discard the partial word and restart at byte 0
//   i_push      - accept i_byte at the current index
//   o_word      - assembled 128-bit word
//   o_index     - index of the next byte to be written
//   o_done      - the byte being pushed completes the word
module cheat_byte_packer
  import cheat_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic [7:0]   i_byte,
  output logic [127:0] o_word,
  output logic [3:0]   o_index,
  output logic         o_done
);

  logic [127:0] r_word;
  logic [3:0]   r_index;

  // Accumulate payload bytes into their field slots
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word  <= 128'd0;
      r_index <= 4'd0;
    end else if (i_clear) begin
      r_word  <= 128'd0;
      r_index <= 4'd0;
    end else if (i_push) begin
      r_word[byte_offset(r_index) +: 8] <= i_byte;
      r_index                           <= r_index + 4'd1;
    end
  end

  assign o_word  = r_word;
  assign o_index = r_index;
  assign o_done  = i_push && (r_index == 4'(PAYLOAD_BYTES - 1));

endmodule

// File: rtl/cheat_loader.sv
// Host-side cheat code sequencer. Decodes the host byte stream, assembles
// 128-bit code words and presents them on the engine's 129-bit bus with a
// load strobe held high then low for STROBE_CYCLES each. Handles engine
// clear (host command or ROM change), enable control and status.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_data    - host byte stream, accepted when in_ready
//   rom_change          - one-cycle pulse, forces an engine clear
//   code                - {strobe, flags, addr, compare, replace}
//   engine_reset        - engine clear, CLEAR_CYCLES long
//   engine_enable       - engine override enable
//   busy, code_count, full, err - host status
module cheat_loader
  import cheat_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int CLEAR_CYCLES  = 2,
  parameter int MAX_CODES     = 32,
  parameter int GAP_TIMEOUT   = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  input  logic                           rom_change,
  output logic [128:0]                   code,
  output logic                           engine_reset,
  output logic                           engine_enable,
  output logic                           busy,
  output logic [$clog2(MAX_CODES+1)-1:0] code_count,
  output logic                           full,
  output logic                           err
);

  localparam int CW    = $clog2(MAX_CODES + 1);
  localparam int CNT_W = $clog2(((STROBE_CYCLES > CLEAR_CYCLES) ? STROBE_CYCLES : CLEAR_CYCLES) + 1);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt, w_next_cnt;
  logic [GAP_W-1:0]   r_gap, w_next_gap;
  logic [128:0]       r_code;
  logic               r_engine_reset;
  logic               r_engine_enable;
  logic [CW-1:0]      r_count;
  logic               r_err;

  logic               w_fire;
  logic               w_pack_clear;
  logic               w_pack_push;
  logic               w_set_err;
  logic               w_en_set;
  logic               w_en_clr;
  logic [127:0]       w_word;
  logic [3:0]         w_index;
  logic               w_done;

  assign w_fire = in_valid && in_ready;

  cheat_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_pack_clear),
    .i_push  (w_pack_push),
    .i_byte  (in_data),
    .o_word  (w_word),
    .o_index (w_index),
    .o_done  (w_done)
  );

  // Next-state decode; rom_change overrides everything and drops any byte
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_gap   = r_gap;
    w_pack_clear = 1'b0;
    w_pack_push  = 1'b0;
    w_set_err    = 1'b0;
    w_en_set     = 1'b0;
    w_en_clr     = 1'b0;
    if (rom_change) begin
      w_next_state = CLR;
      w_next_cnt   = CNT_W'(0);
      w_pack_clear = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            case (in_data)
              OP_CLEAR: begin
                w_next_state = CLR;
                w_next_cnt   = CNT_W'(0);
              end
              OP_LOAD: begin
                w_next_state = COLLECT;
                w_next_gap   = GAP_W'(0);
                w_pack_clear = 1'b1;
              end
              OP_EN:   w_en_set  = 1'b1;
              OP_DIS:  w_en_clr  = 1'b1;
              OP_NOP:  w_set_err = 1'b0;
              default: w_set_err = 1'b1;
            endcase
          end
        end
        COLLECT: begin
          if (w_fire) begin
            w_pack_push = 1'b1;
            w_next_gap  = GAP_W'(0);
            if (w_done) begin
              w_next_state = SETUP;
            end
          end else if (r_gap == GAP_W'(GAP_TIMEOUT - 1)) begin
            w_set_err    = 1'b1;
            w_next_state = IDLE;
            w_pack_clear = 1'b1;
          end else begin
            w_next_gap = r_gap + GAP_W'(1);
          end
        end
        SETUP: begin
          w_next_state = STROBE;
          w_next_cnt   = CNT_W'(0);
        end
        STROBE: begin
          if (r_cnt == CNT_W'(STROBE_CYCLES - 1)) begin
            w_next_state = RELEASE;
            w_next_cnt   = CNT_W'(0);
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == CNT_W'(STROBE_CYCLES - 1)) begin
            w_next_state = IDLE;
            w_next_cnt   = CNT_W'(0);
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        CLR: begin
          if (r_cnt == CNT_W'(CLEAR_CYCLES - 1)) begin
            w_next_state = IDLE;
            w_next_cnt   = CNT_W'(0);
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = CNT_W'(0);
        end
      endcase
    end
  end

  // State, timers and registered engine/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= CNT_W'(0);
      r_gap           <= GAP_W'(0);
      r_code          <= 129'd0;
      r_engine_reset  <= 1'b0;
      r_engine_enable <= 1'b0;
      r_count         <= CW'(0);
      r_err           <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_next_cnt;
      r_gap          <= w_next_gap;
      // Strobe and clear pulses follow the state being entered so they
      // line up exactly with the STROBE and CLR cycles.
      r_code[STROBE_BIT] <= (w_next_state == STROBE);
      r_engine_reset     <= (w_next_state == CLR);
      if (w_next_state == CLR) begin
        r_code[127:0] <= 128'd0;
        r_count       <= CW'(0);
        r_err         <= 1'b0;
      end else begin
        if (r_state == SETUP) begin
          r_code[127:0] <= w_word;
          if (r_count != CW'(MAX_CODES)) begin
            r_count <= r_count + CW'(1);
          end
        end
        if (w_set_err) begin
          r_err <= 1'b1;
        end
      end
      if (w_en_set) begin
        r_engine_enable <= 1'b1;
      end else if (w_en_clr) begin
        r_engine_enable <= 1'b0;
      end
    end
  end

  assign in_ready      = (r_state == IDLE) || (r_state == COLLECT);
  assign busy          = (r_state != IDLE);
  assign code          = r_code;
  assign engine_reset  = r_engine_reset;
  assign engine_enable = r_engine_enable;
  assign code_count    = r_count;
  assign full          = (r_count == CW'(MAX_CODES));
  assign err           = r_err;

endmodule

// File: tb/tb_cheat_loader.sv
// Directed self-checking bench for cheat_loader (GAP_TIMEOUT reduced to 16).
// Inputs change just after the rising edge; outputs are sampled on the
// falling edge.
module tb_cheat_loader;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         rom_change;
  logic [128:0] code;
  logic         engine_reset;
  logic         engine_enable;
  logic         busy;
  logic [5:0]   code_count;
  logic         full;
  logic         err;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic prev_strobe = 1'b0;

  cheat_loader #(
    .STROBE_CYCLES (2),
    .CLEAR_CYCLES  (2),
    .MAX_CODES     (32),
    .GAP_TIMEOUT   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .rom_change    (rom_change),
    .code          (code),
    .engine_reset  (engine_reset),
    .engine_enable (engine_enable),
    .busy          (busy),
    .code_count    (code_count),
    .full          (full),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe rising edges seen by the engine
  always @(posedge clk) begin
    prev_strobe <= code[128];
    if (code[128] && !prev_strobe) rises <= rises + 1;
  end

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic load(input logic [31:0] f, input logic [31:0] a,
                      input logic [31:0] c, input logic [31:0] r);
    send_byte(8'hC1);
    for (int k = 0; k < 4; k++) send_byte(f[8*k +: 8]);
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    for (int k = 0; k < 4; k++) send_byte(c[8*k +: 8]);
    for (int k = 0; k < 4; k++) send_byte(r[8*k +: 8]);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 129'(busy), 129'd0);
  endtask

  initial begin
    int base;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    rom_change = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_code",     code,                  129'd0);
    check("rst_ereset",   129'(engine_reset),    129'd0);
    check("rst_enable",   129'(engine_enable),   129'd0);
    check("rst_count",    129'(code_count),      129'd0);
    check("rst_err",      129'(err),             129'd0);
    check("rst_ready",    129'(in_ready),        129'd1);
    check("rst_busy",     129'(busy),            129'd0);

    // Basic LOAD with exact strobe timing (last byte accepted in cycle N)
    base = rises;
    load(32'h0000_0001, 32'h0000_1234, 32'h0000_00AA, 32'h0000_0055);
    @(negedge clk); // N+1 SETUP
    check("setup_strobe", 129'(code[128]), 129'd0);
    check("setup_ready",  129'(in_ready),  129'd0);
    check("setup_busy",   129'(busy),      129'd1);
    @(negedge clk); // N+2
    check("n2_strobe",    129'(code[128]), 129'd1);
    check("n2_data",      129'(code[127:0]), 129'h00000001_00001234_000000AA_00000055);
    check("n2_count",     129'(code_count), 129'd1);
    @(negedge clk); // N+3
    check("n3_strobe",    129'(code[128]), 129'd1);
    @(negedge clk); // N+4
    check("n4_strobe",    129'(code[128]), 129'd0);
    check("n4_ready",     129'(in_ready),  129'd0);
    check("n4_data",      129'(code[127:0]), 129'h00000001_00001234_000000AA_00000055);
    @(negedge clk); // N+5
    check("n5_strobe",    129'(code[128]), 129'd0);
    check("n5_ready",     129'(in_ready),  129'd0);
    @(negedge clk); // N+6
    check("n6_ready",     129'(in_ready),  129'd1);
    check("n6_busy",      129'(busy),      129'd0);
    check("load1_rises",  129'(rises - base), 129'd1);

    // ENABLE / DISABLE
    send_byte(8'hC2);
    @(negedge clk);
    check("en_on",        129'(engine_enable), 129'd1);
    check("en_busy",      129'(busy),          129'd0);
    send_byte(8'hC3);
    @(negedge clk);
    check("en_off",       129'(engine_enable), 129'd0);
    check("dis_busy",     129'(busy),          129'd0);
    send_byte(8'hC2);  // leave enabled to confirm clears do not touch it

    // Saturation: clear then 33 loads
    send_byte(8'hC0);
    wait_idle();
    check("sat_start",    129'(code_count), 129'd0);
    base = rises;
    for (int i = 1; i <= 33; i++) begin
      load(32'h0000_0100 + 32'(i), 32'h8000_0000 + 32'(i), 32'hDEAD_BEEF, 32'h0BAD_F00D);
      wait_idle();
      if (i == 31) begin
        check("cnt31",    129'(code_count), 129'd31);
        check("full31",   129'(full),       129'd0);
      end
      if (i == 32) begin
        check("cnt32",    129'(code_count), 129'd32);
        check("full32",   129'(full),       129'd1);
      end
    end
    check("cnt33",        129'(code_count), 129'd32);
    check("full33",       129'(full),       129'd1);
    check("rises33",      129'(rises - base), 129'd33);
    check("data33",       129'(code[127:0]), 129'h00000121_80000021_DEADBEEF_0BADF00D);
    send_byte(8'hC0);
    @(negedge clk);
    check("clr1_ereset",  129'(engine_reset), 129'd1);
    check("clr1_count",   129'(code_count),   129'd0);
    check("clr1_full",    129'(full),         129'd0);
    check("clr1_code",    code,               129'd0);
    @(negedge clk);
    check("clr2_ereset",  129'(engine_reset), 129'd1);
    @(negedge clk);
    check("clr3_ereset",  129'(engine_reset), 129'd0);
    check("clr3_busy",    129'(busy),         129'd0);
    check("clr_keeps_en", 129'(engine_enable), 129'd1);

    // rom_change after the 7th payload byte
    load(32'h0000_0007, 32'h0000_0070, 32'h0000_0700, 32'h0000_7000);
    wait_idle();
    base = rises;
    send_byte(8'hC1);
    for (int k = 0; k < 7; k++) send_byte(8'h11 + 8'(k));
    rom_change = 1'b1;
    @(posedge clk);
    #1 rom_change = 1'b0;
    @(negedge clk);
    check("rc_ereset",    129'(engine_reset), 129'd1);
    check("rc_code",      code,               129'd0);
    check("rc_count",     129'(code_count),   129'd0);
    check("rc_busy",      129'(busy),         129'd1);
    wait_idle();
    repeat (6) @(negedge clk);
    check("rc_no_strobe", 129'(rises - base), 129'd0);
    check("rc_keeps_en",  129'(engine_enable), 129'd1);
    load(32'hCAFE_0001, 32'h0040_2000, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_idle();
    check("rc_reload",    129'(code[127:0]), 129'hCAFE0001_00402000_12345678_9ABCDEF0);
    check("rc_recount",   129'(code_count),  129'd1);

    // Bad opcode, then payload gap timeout
    send_byte(8'h7F);
    @(negedge clk);
    check("bad_err",      129'(err),  129'd1);
    check("bad_busy",     129'(busy), 129'd0);
    send_byte(8'hC0);
    wait_idle();
    check("bad_clr_err",  129'(err),  129'd0);
    base = rises;
    send_byte(8'hC1);
    for (int k = 0; k < 5; k++) send_byte(8'hA0 + 8'(k));
    repeat (16) @(negedge clk);
    check("gap_pending",  129'(busy), 129'd1);
    @(negedge clk);
    check("gap_busy",     129'(busy), 129'd0);
    check("gap_err",      129'(err),  129'd1);
    check("gap_no_strb",  129'(rises - base), 129'd0);
    send_byte(8'hC0);
    wait_idle();
    check("gap_clr_err",  129'(err),  129'd0);

    // Reset during STROBE
    load(32'h1, 32'h2, 32'h3, 32'h4);
    @(negedge clk); // SETUP
    @(negedge clk); // STROBE
    check("pre_rst_strb", 129'(code[128]), 129'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_strb", 129'(code[128]),  129'd0);
    check("mid_rst_rdy",  129'(in_ready),   129'd1);
    check("mid_rst_cnt",  129'(code_count), 129'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 129'(busy), 129'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cheat_loader.md
Name: cheat_loader

Overview:
- Host-side controller that sequences cheat codes into the cheat engine.
- Receives a byte command stream from the ESP32 command interface and assembles 128-bit code words from it.
- Drives the engine's 129-bit code bus, including the edge-detected load strobe on bit 128, plus the engine's clear and enable controls.
- Guarantees the strobe timing the engine needs, auto-clears on ROM change, and reports status to the host.

Parameters:
- STROBE_CYCLES, 2, cycles the strobe is held high and then held low per load; must be >=2 so the engine's registered edge detect sees each edge.
- CLEAR_CYCLES, 2, cycles engine_reset is held high per clear.
- MAX_CODES, 32, engine capacity; count saturation point.
- GAP_TIMEOUT, 65535, max idle cycles between bytes of one LOAD payload before it is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- rom_change  in  1  one-cycle pulse on new ROM load; forces clear
- code  out  129  engine code bus: {strobe, flags[31:0], addr[31:0], compare[31:0], replace[31:0]}
- engine_reset  out  1  engine clear
- engine_enable  out  1  engine override enable
- busy  out  1  state != IDLE
- code_count  out  $clog2(MAX_CODES+1)  strobes issued since last clear, saturating
- full  out  1  code_count == MAX_CODES
- err  out  1  sticky; cleared only by CLEAR or reset

Behaviour:
- Reset values: code=0, engine_reset=0, engine_enable=0, code_count=0, err=0, in_ready=1, state=IDLE.
- Reset mid-operation abandons any payload in progress; the strobe drops in the same cycle.
- Opcodes, each taken as the first byte in IDLE:
  - 0xC0 CLEAR
  - 0xC1 LOAD (16 payload bytes follow)
  - 0xC2 ENABLE: engine_enable<=1
  - 0xC3 DISABLE: engine_enable<=0
  - 0x00 NOP
  - any other opcode: err<=1, stay IDLE.
- ENABLE, DISABLE and NOP take effect the cycle after acceptance, with no state change.
- Payload byte order: four 32-bit fields, in order flags, addr, compare, replace. Each field arrives LSB first and is stored as its numeric value (byte k of a field goes to field[8k+7:8k]).
- States:
  - IDLE: in_ready=1. CLEAR opcode -> CLR; LOAD opcode -> COLLECT with byte index=0 and gap timer=0.
  - COLLECT: in_ready=1. Each accepted byte shifts into the packer and increments the index; the 16th byte -> SETUP. The gap timer resets on each byte; reaching GAP_TIMEOUT -> err<=1, IDLE, packer discarded.
  - SETUP (1 cycle): code[127:0]<=packed word, code[128]=0. in_ready=0.
  - STROBE (STROBE_CYCLES): code[128]=1, data held stable. On entry, code_count increments, saturating at MAX_CODES.
  - RELEASE (STROBE_CYCLES): code[128]=0, data held -> IDLE.
  - CLR (CLEAR_CYCLES): engine_reset=1, code=0, code_count<=0, err<=0 -> IDLE.
- Timing:
  - Last payload byte accepted in cycle N: SETUP is cycle N+1, strobe high N+2..N+1+S, low N+2+S..N+1+2S, in_ready high again at N+2+2S (S=STROBE_CYCLES).
  - Opcode accepted in cycle N: CLR occupies cycles N+1..N+CLEAR_CYCLES.
- LOAD while full=1 is still performed; the engine replaces same-address codes or ignores the load. The count stays at MAX_CODES.
- rom_change has priority over everything except reset. In any state it aborts the current activity and enters CLR on the next cycle; if already in CLR, the clear-cycle counter restarts.
- A rom_change arriving in the same cycle as an accepted byte causes that byte to be dropped.
- engine_enable is unaffected by CLEAR and rom_change.

Decomposition:
- Shared package cheat_pkg holds:
  - opcode localparams (OP_NOP, OP_CLEAR, OP_LOAD, OP_EN, OP_DIS)
  - state enum (IDLE, COLLECT, SETUP, STROBE, RELEASE, CLR)
  - field bit offsets (STROBE_BIT=128, FLAGS_LSB=96, ADDR_LSB=64, CMP_LSB=32, REP_LSB=0)
  - PAYLOAD_BYTES=16
- One sub-module, cheat_byte_packer: a 128-bit byte accumulator with byte index, clear and done outputs, implementing the per-field LSB-first placement.

Test Plan:
- Reset, then LOAD with flags 01 00 00 00, addr 34 12 00 00, compare AA 00 00 00, replace 55 00 00 00 -> code[127:0]=0x00000001_00001234_000000AA_00000055; code[128] high exactly 2 cycles starting N+2, then low 2 cycles; code_count=1; in_ready returns at N+6.
- 0xC2 then 0xC3 -> engine_enable 1 the cycle after the first byte, 0 the cycle after the second; busy stays 0 throughout.
- 33 back-to-back LOADs -> code_count saturates at 32, full=1; the 33rd strobe is still issued. Then CLEAR -> engine_reset high 2 cycles, code_count=0, full=0.
- rom_change pulsed after the 7th payload byte -> CLR the next cycle; no strobe issued; code=0; a following full LOAD works normally.
- Opcode 0x7F -> err=1, stays IDLE. LOAD with 5 bytes then GAP_TIMEOUT idle cycles (test with GAP_TIMEOUT=16) -> err=1, IDLE, no strobe. CLEAR -> err=0.
- Reset asserted during STROBE -> code[128]=0 and in_ready=1 the cycle after reset is sampled; code_count=0.
